// File: rtl/counter_sequencer_if.sv
// Handshake bundle between the board-side controls/counter datapath and counter_sequencer.
// The sequencer uses the slave modport; the board/datapath side uses master.
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic [1:0]       mode;
   logic [WIDTH-1:0] count;
   logic             cnt_en;
   logic             cnt_up;
   logic             cnt_load;
   logic [WIDTH-1:0] load_val;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, stop, mode, count,
      input  cnt_en, cnt_up, cnt_load, load_val, busy, done, state
   );

   modport slave (
      input  start, stop, mode, count,
      output cnt_en, cnt_up, cnt_load, load_val, busy, done, state
   );
endinterface

// File: rtl/counter_sequencer.sv
// Run-mode controller for the LED counter: prescaled step tick, direction, load strobe.
// Optional macro PINGPONG_EN compiles the ping-pong direction logic for mode 10.
module counter_sequencer #(
   parameter int WIDTH = 4,
   parameter int DIV   = 100_000_000,
   parameter int LO    = 0,
   parameter int HI    = 15
) (
   input logic               clk,
   input logic               rst,
   counter_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int               PW        = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] LO_V      = WIDTH'(LO);
   localparam logic [WIDTH-1:0] HI_V      = WIDTH'(HI);
   localparam logic [WIDTH-1:0] HI_M1     = WIDTH'(HI - 1);
`ifdef PINGPONG_EN
   localparam logic [WIDTH-1:0] LO_P1     = WIDTH'(LO + 1);
`endif

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             cnt_en_q, cnt_en_d;
   logic             cnt_up_q, cnt_up_d;
   logic             cnt_load_q, cnt_load_d;
   logic [WIDTH-1:0] load_val_q, load_val_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= 2'b00;
         presc_q    <= '0;
         cnt_en_q   <= 1'b0;
         cnt_up_q   <= 1'b1;
         cnt_load_q <= 1'b0;
         load_val_q <= LO_V;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         presc_q    <= presc_d;
         cnt_en_q   <= cnt_en_d;
         cnt_up_q   <= cnt_up_d;
         cnt_load_q <= cnt_load_d;
         load_val_q <= load_val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Outputs are registered, so everything is derived from the next state.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      presc_d    = '0;
      cnt_en_d   = 1'b0;
      cnt_up_d   = cnt_up_q;
      cnt_load_d = 1'b0;
      load_val_d = load_val_q;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = LOAD;
               mode_d  = bus.mode;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
               if (cnt_en_q) begin
                  if (mode_q == 2'b11 && bus.count == HI_M1) begin
                     state_d = DONE;
                  end
`ifdef PINGPONG_EN
                  if (mode_q == 2'b10) begin
                     if (cnt_up_q && bus.count == HI_M1) begin
                        cnt_up_d = 1'b0;
                     end else if (!cnt_up_q && bus.count == LO_P1) begin
                        cnt_up_d = 1'b1;
                     end
                  end
`endif
               end
            end
         end
         DONE: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (bus.start) begin
               state_d = LOAD;
               mode_d  = bus.mode;
            end
         end
         default: state_d = IDLE;
      endcase

      // Load value and starting direction come from the freshly latched mode.
      if (state_d == LOAD) begin
         cnt_load_d = 1'b1;
         load_val_d = (mode_d == 2'b01) ? HI_V : LO_V;
         cnt_up_d   = (mode_d != 2'b01);
      end

      if (state_d == RUN) begin
         cnt_en_d = (presc_d == PRESC_MAX);
      end

      busy_d = (state_d == LOAD) || (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign bus.cnt_en   = cnt_en_q;
   assign bus.cnt_up   = cnt_up_q;
   assign bus.cnt_load = cnt_load_q;
   assign bus.load_val = load_val_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (DIV=4, LO=0, HI=15) with an attached 4-bit counter model.
// Mode-10 expectations follow PINGPONG_EN the same way the design does.
module tb_counter_sequencer;

   localparam int WIDTH = 4;
   localparam int DIV   = 4;
   localparam int LO    = 0;
   localparam int HI    = 15;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

   counter_sequencer #(
      .WIDTH (WIDTH),
      .DIV   (DIV),
      .LO    (LO),
      .HI    (HI)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter register driven by the sequencer, wrapping at the bounds.
   always @(posedge clk) begin
      if (!rst) begin
         bus.count <= WIDTH'(LO);
      end else if (bus.cnt_load) begin
         bus.count <= bus.load_val;
      end else if (bus.cnt_en) begin
         if (bus.cnt_up) begin
            bus.count <= (bus.count == WIDTH'(HI)) ? WIDTH'(LO) : bus.count + 1'b1;
         end else begin
            bus.count <= (bus.count == WIDTH'(LO)) ? WIDTH'(HI) : bus.count - 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic start_v, input logic stop_v, input logic [1:0] mode_v);
      bus.start = start_v;
      bus.stop  = stop_v;
      bus.mode  = mode_v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until a cnt_en pulse is visible; returns the number of edges taken.
   task automatic wait_step(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.cnt_en !== 1'b1 && n < 20);
      if (bus.cnt_en !== 1'b1) checkOutput("stepTimeout", 0, 1);
   endtask

   // Start a run in the given mode and check the LOAD cycle and RUN entry.
   task automatic begin_run(input logic [1:0] m, input int exp_load, input int exp_up);
      applyStimulus(1'b1, 1'b0, m);
      tick();
      checkOutput("loadState", bus.state, 1);
      checkOutput("loadStrobe", bus.cnt_load, 1);
      checkOutput("loadVal", bus.load_val, exp_load);
      checkOutput("loadDir", bus.cnt_up, exp_up);
      checkOutput("loadBusy", bus.busy, 1);
      applyStimulus(1'b0, 1'b0, m);
      tick();
      checkOutput("runState", bus.state, 2);
      checkOutput("runStrobeOff", bus.cnt_load, 0);
      checkOutput("runCount", bus.count, exp_load);
   endtask

   task automatic stop_and_freeze(input int exp_count);
      int frozen;
      applyStimulus(1'b0, 1'b1, bus.mode);
      tick();
      checkOutput("stopState", bus.state, 0);
      checkOutput("stopBusy", bus.busy, 0);
      checkOutput("stopCount", bus.count, exp_count);
      applyStimulus(1'b0, 1'b0, bus.mode);
      frozen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.cnt_en !== 1'b0) frozen++;
      end
      checkOutput("stopNoStep", frozen, 0);
      checkOutput("stopFrozen", bus.count, exp_count);
   endtask

   initial begin
      int n;
      int exp_c;
      int exp_u;
      int bad;

      n_checks = 0;
      n_fails  = 0;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'b00);
      tick();
      tick();
      checkOutput("rstState", bus.state, 0);
      checkOutput("rstCntEn", bus.cnt_en, 0);
      checkOutput("rstCntUp", bus.cnt_up, 1);
      checkOutput("rstLoadVal", bus.load_val, 0);
      checkOutput("rstBusy", bus.busy, 0);
      checkOutput("rstDone", bus.done, 0);
      rst = 1'b1;
      tick();

      // Mode 00: first pulse three edges after RUN entry, then every four.
      begin_run(2'b00, 0, 1);
      tick();
      checkOutput("up1stGap0", bus.cnt_en, 0);
      tick();
      checkOutput("up1stGap1", bus.cnt_en, 0);
      tick();
      checkOutput("up1stPulse", bus.cnt_en, 1);
      checkOutput("up1stCount", bus.count, 0);
      tick();
      checkOutput("upPulseWidth", bus.cnt_en, 0);
      checkOutput("upAfter1st", bus.count, 1);
      bad = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 1) begin
            n = 0;
            do begin
               tick();
               n++;
            end while (bus.cnt_en !== 1'b1 && n < 20);
            checkOutput("upPeriodTail", n, 3);
         end else begin
            wait_step(n);
            if (n != 4) bad++;
         end
         checkOutput("upCount", bus.count, i % 16);
      end
      checkOutput("upPeriod", bad, 0);
      stop_and_freeze(1);

      // Mode 01: count 15 down to 0 then wraps to 15; reset lands mid-run.
      begin_run(2'b01, 15, 0);
      wait_step(n);
      checkOutput("dn1stGap", n, 3);
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) wait_step(n);
         checkOutput("dnCount", bus.count, (15 - i) & 15);
         checkOutput("dnDir", bus.cnt_up, 0);
      end
      rst = 1'b0;
      tick();
      tick();
      checkOutput("midRstState", bus.state, 0);
      checkOutput("midRstCntEn", bus.cnt_en, 0);
      checkOutput("midRstCntUp", bus.cnt_up, 1);
      checkOutput("midRstLoadVal", bus.load_val, 0);
      checkOutput("midRstBusy", bus.busy, 0);
      rst = 1'b1;
      tick();
      checkOutput("postRstState", bus.state, 0);
      checkOutput("postRstCntEn", bus.cnt_en, 0);

      // Mode 10: ping-pong 0..15,14..0,1 when enabled, plain up-count otherwise.
      begin_run(2'b10, 0, 1);
      wait_step(n);
      checkOutput("pp1stGap", n, 3);
      for (int i = 0; i <= 31; i++) begin
         if (i > 0) wait_step(n);
`ifdef PINGPONG_EN
         exp_c = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
         exp_u = (i <= 14 || i >= 30) ? 1 : 0;
`else
         exp_c = i % 16;
         exp_u = 1;
`endif
         checkOutput("ppCount", bus.count, exp_c);
         checkOutput("ppDir", bus.cnt_up, exp_u);
      end
      applyStimulus(1'b0, 1'b1, 2'b10);
      tick();
      checkOutput("ppStopState", bus.state, 0);
      applyStimulus(1'b0, 1'b0, 2'b10);
      tick();

      // Mode 11: final step to 15 then DONE, no further steps, restart reloads 0.
      begin_run(2'b11, 0, 1);
      wait_step(n);
      checkOutput("os1stGap", n, 3);
      for (int i = 0; i <= 14; i++) begin
         if (i > 0) wait_step(n);
         checkOutput("osCount", bus.count, i);
      end
      tick();
      checkOutput("osDoneState", bus.state, 3);
      checkOutput("osDone", bus.done, 1);
      checkOutput("osBusy", bus.busy, 0);
      checkOutput("osFinal", bus.count, 15);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.cnt_en !== 1'b0) bad++;
      end
      checkOutput("osNoStep", bad, 0);
      checkOutput("osHold", bus.count, 15);
      begin_run(2'b11, 0, 1);
      checkOutput("osRestartDone", bus.done, 0);

      // Stop mid-run, then start+stop together in IDLE must not leave IDLE.
      applyStimulus(1'b0, 1'b1, 2'b11);
      tick();
      checkOutput("osStopState", bus.state, 0);
      applyStimulus(1'b1, 1'b1, 2'b00);
      tick();
      checkOutput("bothIdle0", bus.state, 0);
      checkOutput("bothNoLoad", bus.cnt_load, 0);
      tick();
      checkOutput("bothIdle1", bus.state, 0);
      checkOutput("bothBusy", bus.busy, 0);
      applyStimulus(1'b0, 1'b0, 2'b00);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
